// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter for one like-SRAM port: address-phase grant with lock until addr_ok,
// plus an in-order source-ID FIFO that steers each data_ok/rdata back to its requester.
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // IF-stage requester
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // EX-stage requester
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_D = 2'd1,
    LOCK_I = 2'd2
  } lock_state_e;

  lock_state_e       state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              proto_err_q, proto_err_d;
  logic              fifo_q [MAX_OUTSTANDING];

  logic gnt_d_s, gnt_i_s, granted_req_s, not_full_s;
  logic mem_req_s, push_s, pop_s, head_s;

  // Grant selection: data wins in IDLE, locked master keeps the grant otherwise.
  always_comb begin
    gnt_d_s = 1'b0;
    gnt_i_s = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d_s = data_req;
        gnt_i_s = inst_req & ~data_req;
      end
      LOCK_D:  gnt_d_s = 1'b1;
      LOCK_I:  gnt_i_s = 1'b1;
      default: begin
        gnt_d_s = 1'b0;
        gnt_i_s = 1'b0;
      end
    endcase
  end

  // Request qualification against the registered occupancy only (no data_ok -> req path).
  always_comb begin
    granted_req_s = 1'b0;
    if (gnt_d_s) begin
      granted_req_s = data_req;
    end else if (gnt_i_s) begin
      granted_req_s = inst_req;
    end else begin
      granted_req_s = 1'b0;
    end
    not_full_s = (count_q < CNT_W'(MAX_OUTSTANDING));
    mem_req_s  = resetn & granted_req_s & not_full_s;
    push_s     = mem_req_s & mem_addr_ok;
    pop_s      = mem_data_ok & (count_q != CNT_W'(0));
    head_s     = fifo_q[rd_ptr_q];
  end

  // Lock FSM next state; a dropped locked request releases the lock defensively.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_req_s && !mem_addr_ok) begin
          if (gnt_d_s) begin
            state_d = LOCK_D;
          end else begin
            state_d = LOCK_I;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCK_D: begin
        if (mem_addr_ok || !data_req) begin
          state_d = IDLE;
        end else begin
          state_d = LOCK_D;
        end
      end
      LOCK_I: begin
        if (mem_addr_ok || !inst_req) begin
          state_d = IDLE;
        end else begin
          state_d = LOCK_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer/occupancy next state and sticky protocol error.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    proto_err_d = proto_err_q | (mem_data_ok & (count_q == CNT_W'(0)));
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Source-ID storage: 1 marks a data-side transaction, 0 an inst-side one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= 1'b0;
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= gnt_d_s;
    end
  end

  // Output steering; with no grant the fields follow the data side.
  always_comb begin
    mem_req      = mem_req_s;
    mem_wr       = gnt_i_s ? inst_wr    : data_wr;
    mem_size     = gnt_i_s ? inst_size  : data_size;
    mem_wstrb    = gnt_i_s ? inst_wstrb : data_wstrb;
    mem_addr     = gnt_i_s ? inst_addr  : data_addr;
    mem_wdata    = gnt_i_s ? inst_wdata : data_wdata;
    inst_addr_ok = push_s & gnt_i_s;
    data_addr_ok = push_s & gnt_d_s;
    inst_data_ok = resetn & pop_s & ~head_s;
    data_data_ok = resetn & pop_s & head_s;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    proto_err    = proto_err_q;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized bench for sram_bus_arbiter against a transaction-level model:
// a queue of outstanding sources, a lock owner and a sticky error flag.
module tb_sram_bus_arbiter;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        inst_req = 1'b0, inst_wr = 1'b0, data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  inst_size = 2'd0, data_size = 2'd0;
  logic [3:0]  inst_wstrb = 4'd0, data_wstrb = 4'd0;
  logic [31:0] inst_addr = 32'd0, inst_wdata = 32'd0, data_addr = 32'd0, data_wdata = 32'd0;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        proto_err;

  sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding sources (1=data, 0=inst), lock owner (0 none, 1 data, 2 inst).
  bit q[$];
  int owner = 0;
  bit m_proto = 1'b0;
  bit e_gd, e_gi, e_mreq, e_hs, e_pop, e_ia, e_da, e_id, e_dd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    owner   = 0;
    m_proto = 1'b0;
  endtask

  task automatic model_eval();
    e_gd = 1'b0;
    e_gi = 1'b0;
    if (owner == 1) e_gd = 1'b1;
    else if (owner == 2) e_gi = 1'b1;
    else begin
      e_gd = data_req;
      e_gi = inst_req && !data_req;
    end
    e_mreq = resetn && (e_gd ? data_req : (e_gi ? inst_req : 1'b0)) && (q.size() < MAXO);
    e_hs   = e_mreq && mem_addr_ok;
    e_ia   = e_hs && e_gi;
    e_da   = e_hs && e_gd;
    e_pop  = resetn && mem_data_ok && (q.size() > 0);
    e_dd   = e_pop && q[0];
    e_id   = e_pop && !q[0];
  endtask

  task automatic compare();
    model_eval();
    check_eq("mem_req", 32'(mem_req), 32'(e_mreq));
    check_eq("mem_addr", mem_addr, e_gi ? inst_addr : data_addr);
    check_eq("mem_wdata", mem_wdata, e_gi ? inst_wdata : data_wdata);
    check_eq("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
             e_gi ? {25'd0, inst_wr, inst_size, inst_wstrb} : {25'd0, data_wr, data_size, data_wstrb});
    check_eq("inst_addr_ok", 32'(inst_addr_ok), 32'(e_ia));
    check_eq("data_addr_ok", 32'(data_addr_ok), 32'(e_da));
    check_eq("inst_data_ok", 32'(inst_data_ok), 32'(e_id));
    check_eq("data_data_ok", 32'(data_data_ok), 32'(e_dd));
    check_eq("rdata", {inst_rdata ^ data_rdata} | inst_rdata, mem_rdata);
    check_eq("proto_err", 32'(proto_err), 32'(m_proto));
  endtask

  task automatic model_advance();
    if (!resetn) begin
      model_reset();
    end else begin
      if (mem_data_ok && q.size() == 0) m_proto = 1'b1;
      if (e_pop) void'(q.pop_front());
      if (e_hs) q.push_back(e_gd);
      if (owner == 0) begin
        if (e_mreq && !mem_addr_ok) owner = e_gd ? 1 : 2;
      end else if (mem_addr_ok || (owner == 1 && !data_req) || (owner == 2 && !inst_req)) begin
        owner = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic drive_random();
    if (!inst_req || e_ia) begin
      inst_req   = 1'($urandom_range(0, 1));
      inst_wr    = 1'($urandom_range(0, 1));
      inst_size  = 2'($urandom_range(0, 2));
      inst_wstrb = 4'($urandom);
      inst_addr  = $urandom;
      inst_wdata = $urandom;
    end else if ($urandom_range(0, 19) == 0) begin
      inst_req = 1'b0;
    end
    if (!data_req || e_da) begin
      data_req   = 1'($urandom_range(0, 1));
      data_wr    = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 2));
      data_wstrb = 4'($urandom);
      data_addr  = $urandom;
      data_wdata = $urandom;
    end else if ($urandom_range(0, 19) == 0) begin
      data_req = 1'b0;
    end
    mem_addr_ok = 1'($urandom_range(0, 1));
    mem_data_ok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
    mem_rdata   = $urandom;
  endtask

  initial begin
    model_reset();
    #12;
    cycle();
    check_eq("reset_mem_req", 32'(mem_req), 32'd0);
    check_eq("reset_proto", 32'(proto_err), 32'd0);
    resetn = 1'b1;
    #1;

    // Zero-latency inst read and its response.
    inst_req = 1'b1; inst_addr = 32'h1c000000; mem_addr_ok = 1'b1;
    @(negedge clk);
    check_eq("t1_addr", mem_addr, 32'h1c000000);
    check_eq("t1_addr_ok", 32'(inst_addr_ok), 32'd1);
    @(posedge clk); #1;
    cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    resetn = 1'b0; #1; resetn = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h1c000000; mem_addr_ok = 1'b1;
    cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h02800c0c;
    @(negedge clk);
    check_eq("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
    check_eq("t1_data_data_ok", 32'(data_data_ok), 32'd0);
    check_eq("t1_rdata", inst_rdata, 32'h02800c0c);
    @(posedge clk); model_eval(); model_advance(); #1;
    mem_data_ok = 1'b0;
    cycle();

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      if (i == 1500) begin
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("async_rst_addr_ok", 32'(inst_addr_ok | data_addr_ok), 32'd0);
      end
      if (i == 1503) resetn = 1'b1;
      cycle();
    end

    // Drain, then a spurious response sets the sticky error.
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      mem_data_ok = 1'b1;
      cycle();
    end
    check_eq("drain_empty", 32'(q.size()), 32'd0);
    mem_data_ok = 1'b1;
    cycle();
    mem_data_ok = 1'b0;
    cycle();
    cycle();
    check_eq("proto_sticky", 32'(proto_err), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("proto_cleared", 32'(proto_err), 32'd0);
    model_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
